aes_serial_load_ctrl: RTL
=========================

Name: aes_serial_load_ctrl

Overview:
Controller that sequences the 1-to-8 serial-in/parallel-out deserializer on the AES input path. It gates the serial bitstream into the SIPO and collects SIPO output bytes into one 128-bit block (key or plaintext). It hands the block to the AES core over a valid/ready handshake and aborts cleanly when the serial stream stalls.

Parameters:
BLOCK_BYTES, 16, bytes per assembled block; the block is 8*BLOCK_BYTES bits.
TIMEOUT, 64, LOAD-state cycles with ser_valid low before abort; 0 disables the timeout.
CNT_W, 5, width of byte_cnt; must hold the value BLOCK_BYTES.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin loading a block.
ser_valid  input  1  ser_in carries a valid bit this cycle.
ser_in  input  1  serial data bit.
sipo_en  output  1  SIPO shift enable.
sipo_in  output  1  SIPO serial data.
sipo_clr  output  1  one-cycle clear of the SIPO bit counter and shift register.
sipo_valid  input  1  SIPO byte complete; sipo_out is valid this cycle.
sipo_out  input  8  SIPO parallel byte; first-received bit is the MSB.
blk_data  output  8*BLOCK_BYTES  assembled block; first byte in the MSBs.
blk_valid  output  1  blk_data is complete and stable.
blk_ready  input  1  consumer accepts the block.
busy  output  1  high in the CLR, LOAD and HOLD states.
byte_cnt  output  CNT_W  number of bytes collected in the current block.
err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE.
  - blk_data, blk_valid, busy, byte_cnt, err, sipo_clr all go to 0; the idle counter goes to 0.
  - sipo_en is 0 because its state term is 0.
- States: IDLE, CLR, LOAD, HOLD.
- IDLE -> CLR when start=1.
- CLR lasts exactly one cycle:
  - sipo_clr=1, byte_cnt<=0, blk_data<=0, idle counter<=0.
  - Next state is LOAD.
- LOAD, combinational outputs:
  - sipo_en = ser_valid.
  - sipo_in = ser_in.
- LOAD, on sipo_valid=1:
  - blk_data <= {blk_data[8*BLOCK_BYTES-9:0], sipo_out}.
  - byte_cnt <= byte_cnt+1.
- LOAD -> HOLD: taken on the sipo_valid that brings byte_cnt to BLOCK_BYTES. blk_valid rises on the next clock edge, so latency is 1 cycle after the last sipo_valid.
- Idle counter (LOAD only):
  - Clears on ser_valid=1; otherwise increments, saturating.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT: err=1 for one cycle and sipo_clr=1 for one cycle, both registered and coincident with entering IDLE.
  - byte_cnt<=0; blk_data keeps its partial contents; blk_valid stays 0.
- HOLD:
  - blk_valid=1; blk_data and byte_cnt are frozen.
  - sipo_en=0: ser_valid bits are dropped and sipo_valid is ignored.
  - blk_ready=1 -> IDLE; blk_valid=0 from the next cycle.
  - start=1 together with blk_ready=1 -> CLR directly (back-to-back blocks, no IDLE cycle).
- Ignored events:
  - start in CLR, LOAD, or HOLD without blk_ready.
  - sipo_valid outside LOAD.
  - blk_ready outside HOLD.
- sipo_valid in the same cycle the timeout fires: the timeout takes priority and the byte is discarded.
- Reset during any state: abort to IDLE on the same edge, partial block discarded, no err and no sipo_clr pulse (the SIPO is reset by the same reset).
- busy is registered from state; it equals 1 in CLR, LOAD and HOLD.

Test Plan:
1. Hold reset 3 cycles with start, ser_valid and sipo_valid toggling -> all outputs 0; state stays IDLE after release until start.
2. Load, using a behavioural SIPO model: pulse start, then send 128 bits continuously for bytes 0x00,0x11,...,0xFF -> sipo_clr for 1 cycle after start; blk_valid rises 1 cycle after the 16th sipo_valid; blk_data=0x00112233445566778899AABBCCDDEEFF; byte_cnt=16.
3. Backpressure: after scenario 2, hold blk_ready=0 for 20 cycles while ser_valid=1 -> sipo_en stays 0; blk_data unchanged. Then blk_ready=1 for 1 cycle -> blk_valid=0 and busy=0 on the next cycle.
4. Timeout with TIMEOUT=16: send 5 bytes, then ser_valid=0 -> err and sipo_clr pulse once, 16 cycles after the last valid bit; byte_cnt=0; busy=0; blk_valid never asserts.
5. Back-to-back: in HOLD, drive start=1 and blk_ready=1 in the same cycle -> CLR next cycle. A second block of 0xA5 bytes yields blk_data of all A5.
6. Reset mid-LOAD: assert reset after byte 7 -> outputs 0 on the next edge. A new start plus 16 bytes yields a correct block with no stale bytes.

Source files
------------

// File: rtl/aes_serial_load_ctrl.sv
// ----------------------------------------------------------------------------
// aes_serial_load_ctrl
// Sequences the 1-to-8 SIPO deserializer on the AES input path. The controller
// gates the serial bitstream into the SIPO and packs the SIPO output bytes into
// one 8*BLOCK_BYTES-bit block, first byte in the MSBs. It then offers the block
// to the AES core over a valid/ready handshake. If the serial stream stalls for
// TIMEOUT cycles while loading, the load is aborted and err pulses.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      one-cycle request to begin loading a block
//   ser_valid_i  ser_in_i carries a valid bit this cycle
//   ser_in_i     serial data bit
//   sipo_en_o    SIPO shift enable (only while loading)
//   sipo_in_o    SIPO serial data
//   sipo_clr_o   one-cycle clear of the SIPO
//   sipo_valid_i SIPO byte complete, sipo_out_i valid
//   sipo_out_i   SIPO parallel byte, first-received bit in the MSB
//   blk_data_o   assembled block, first byte in the MSBs
//   blk_valid_o  blk_data_o is complete and stable
//   blk_ready_i  consumer accepts the block
//   busy_o       high in CLR, LOAD and HOLD
//   byte_cnt_o   bytes collected in the current block
//   err_o        one-cycle pulse on timeout abort
// ----------------------------------------------------------------------------
module aes_serial_load_ctrl #(
   parameter int BLOCK_BYTES = 16,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 5
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   input  logic                     ser_valid_i,
   input  logic                     ser_in_i,
   output logic                     sipo_en_o,
   output logic                     sipo_in_o,
   output logic                     sipo_clr_o,
   input  logic                     sipo_valid_i,
   input  logic [7:0]               sipo_out_i,
   output logic [8*BLOCK_BYTES-1:0] blk_data_o,
   output logic                     blk_valid_o,
   input  logic                     blk_ready_i,
   output logic                     busy_o,
   output logic [CNT_W-1:0]         byte_cnt_o,
   output logic                     err_o
);

   localparam int BW = 8 * BLOCK_BYTES;
   // Idle counter must be able to hold TIMEOUT; keep at least one bit.
   localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit              TO_EN     = (TIMEOUT != 0);
   localparam logic [IW-1:0]   TIMEOUT_V = IW'(TIMEOUT);
   localparam logic [IW-1:0]   IDLE_MAX  = '1;
   localparam logic [IW-1:0]   IDLE_ONE  = IW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_LOAD = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   state_e          state_q,     state_d;
   logic [BW-1:0]   blk_data_q,  blk_data_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [IW-1:0]   idle_cnt_q,  idle_cnt_d;
   logic            blk_valid_q, blk_valid_d;
   logic            busy_q,      busy_d;
   logic            err_q,       err_d;
   logic            sipo_clr_q,  sipo_clr_d;
   logic            timeout_s;

   // Next-state and next-output computation for the load sequencer.
   always_comb begin
      state_d    = state_q;
      blk_data_d = blk_data_q;
      byte_cnt_d = byte_cnt_q;
      idle_cnt_d = idle_cnt_q;
      timeout_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_CLR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLR: begin
            byte_cnt_d = '0;
            blk_data_d = '0;
            idle_cnt_d = '0;
            state_d    = ST_LOAD;
         end
         ST_LOAD: begin
            // Stall detector: any valid bit restarts the count, else saturate up.
            if (ser_valid_i) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q != IDLE_MAX) begin
               idle_cnt_d = idle_cnt_q + IDLE_ONE;
            end else begin
               idle_cnt_d = idle_cnt_q;
            end
            // Timeout wins over a byte arriving on the same cycle.
            if (TO_EN && (idle_cnt_d == TIMEOUT_V)) begin
               timeout_s  = 1'b1;
               byte_cnt_d = '0;
               state_d    = ST_IDLE;
            end else if (sipo_valid_i) begin
               blk_data_d = {blk_data_q[BW-9:0], sipo_out_i};
               byte_cnt_d = byte_cnt_q + CNT_ONE;
               if (byte_cnt_q == LAST_CNT) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_HOLD: begin
            // start together with blk_ready chains straight into the next block.
            if (blk_ready_i) begin
               if (start_i) begin
                  state_d = ST_CLR;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Registered outputs are derived from the state being entered.
      busy_d      = (state_d != ST_IDLE);
      blk_valid_d = (state_d == ST_HOLD);
      sipo_clr_d  = (state_d == ST_CLR) | timeout_s;
      err_d       = timeout_s;
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         blk_data_q  <= '0;
         byte_cnt_q  <= '0;
         idle_cnt_q  <= '0;
         blk_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         sipo_clr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_data_q  <= blk_data_d;
         byte_cnt_q  <= byte_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         blk_valid_q <= blk_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         sipo_clr_q  <= sipo_clr_d;
      end
   end

   // The serial path is gated straight through while loading only.
   assign sipo_en_o   = (state_q == ST_LOAD) & ser_valid_i;
   assign sipo_in_o   = (state_q == ST_LOAD) & ser_in_i;
   assign sipo_clr_o  = sipo_clr_q;
   assign blk_data_o  = blk_data_q;
   assign blk_valid_o = blk_valid_q;
   assign busy_o      = busy_q;
   assign byte_cnt_o  = byte_cnt_q;
   assign err_o       = err_q;

endmodule
